// File: rtl/sync_frame_pkg.sv
// Purpose: shared types and default sizing for the frame-sync deserializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sync_frame_pkg;

    // Deserializer control states
    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } sync_frame_state_t;

    localparam int SYNC_FRAME_PAYLOAD_W = 8;
    localparam int SYNC_FRAME_CNT_W     = 16;

endpackage : sync_frame_pkg

// File: rtl/sync_frame_out_buf.sv
// Purpose: one-deep valid/ready holding register for completed payload words.
// Latency: a load appears on data_out/data_valid one cycle later.
// Backpressure: a load while full and not being drained is dropped and flagged by a one-cycle overrun pulse.
module sync_frame_out_buf
    import sync_frame_pkg::*;
#(
    parameter int PAYLOAD_W = SYNC_FRAME_PAYLOAD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [PAYLOAD_W-1:0] load_data,
    input  logic                 data_ready,
    output logic [PAYLOAD_W-1:0] data_out,
    output logic                 data_valid,
    output logic                 overrun,
    output logic                 accept
);

    logic [PAYLOAD_W-1:0] data_q;
    logic                 valid_q;
    logic                 overrun_q;
    logic                 can_load;

    // The buffer frees up in the same cycle it is drained, so a load can ride on an accept
    assign accept   = valid_q & data_ready;
    assign can_load = ~valid_q | data_ready;

    // Holding register: load wins over drain, a blocked load only raises overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= load & ~can_load;
            if (load && can_load) begin
                data_q  <= load_data;
                valid_q <= 1'b1;
            end else if (accept) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign overrun    = overrun_q;

endmodule : sync_frame_out_buf

// File: rtl/sync_frame_deserializer.sv
// Purpose: collects PAYLOAD_W serial bits (MSB first) after each sync pulse into a word; optional SYNC_FRAME_RESYNC_EN restarts a frame on mid-frame sync.
// Latency: data_valid rises PAYLOAD_W cycles after the sync cycle.
// Backpressure: one-deep output; a word completing while the held word is stalled is dropped with an overrun pulse.
module sync_frame_deserializer
    import sync_frame_pkg::*;
#(
    parameter int PAYLOAD_W = SYNC_FRAME_PAYLOAD_W,
    parameter int CNT_W     = SYNC_FRAME_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a,
    input  logic                 sync,
    output logic [PAYLOAD_W-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 overrun,
    output logic [CNT_W-1:0]     frame_cnt
);

    localparam int               BCW      = $clog2(PAYLOAD_W + 1);
    localparam logic [BCW-1:0]   LAST_IDX = BCW'(PAYLOAD_W - 1);

    sync_frame_state_t    state_q, state_d;
    logic [PAYLOAD_W-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]     frame_cnt_q;
    logic [PAYLOAD_W-1:0] shifted;
    logic                 complete;
    logic                 accept;
    logic                 unused_shreg_msb;

    // Shift register with the current serial bit appended at the LSB
    generate
        if (PAYLOAD_W == 1) begin : g_shift_1
            assign shifted = a;
        end else begin : g_shift_n
            assign shifted = {shreg_q[PAYLOAD_W-2:0], a};
        end
    endgenerate

    // The MSB is shifted out on completion; only the low bits seed the next word
    assign unused_shreg_msb = shreg_q[PAYLOAD_W-1];

    // Sequencing state: hunt for sync, then count payload bits
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next-state and completion decode
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        complete  = 1'b0;
        case (state_q)
            HUNT: begin
                if (sync) begin
                    shreg_d   = shifted;
                    bit_cnt_d = BCW'(1);
                    if (PAYLOAD_W == 1) begin
                        complete = 1'b1;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
`ifdef SYNC_FRAME_RESYNC_EN
                if (sync) begin
                    // Restart: current bit becomes bit 0, partial word discarded silently
                    shreg_d    = '0;
                    shreg_d[0] = a;
                    bit_cnt_d  = BCW'(1);
                end else
`endif
                begin
                    shreg_d   = shifted;
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == LAST_IDX) begin
                        complete = 1'b1;
                        state_d  = HUNT;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    sync_frame_out_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (complete),
        .load_data  (shifted),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun),
        .accept     (accept)
    );

    // Accepted-word counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (accept) begin
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        end
    end

    assign frame_cnt = frame_cnt_q;

endmodule : sync_frame_deserializer

// File: tb/tb_sync_frame_deserializer.sv
module tb_sync_frame_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       a;
    logic       sync;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic       overrun;
    logic [15:0] frame_cnt;

    logic [7:0] w2_data_out;
    logic       w2_data_valid;
    logic       w2_overrun;
    logic [1:0] w2_frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sync_frame_deserializer #(.PAYLOAD_W(8), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .sync       (sync),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .frame_cnt  (frame_cnt)
    );

    sync_frame_deserializer #(.PAYLOAD_W(8), .CNT_W(2)) u_dut_w2 (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .sync       (sync),
        .data_out   (w2_data_out),
        .data_valid (w2_data_valid),
        .data_ready (data_ready),
        .overrun    (w2_overrun),
        .frame_cnt  (w2_frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one cycle; inputs set before the call are sampled at this edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        sync = 1'b0;
        a    = 1'b0;
        tick();
        tick();
        rst  = 1'b0;
    endtask

    // Drive one frame, sync with the first bit; optionally raise ready only in the completing cycle
    task automatic send_frame(input logic [7:0] w, input bit rdy_last);
        for (int i = 0; i < 8; i++) begin
            sync = (i == 0);
            a    = w[7-i];
            if (rdy_last && i == 7) data_ready = 1'b1;
            tick();
        end
        sync = 1'b0;
        a    = 1'b0;
        if (rdy_last) data_ready = 1'b0;
    endtask

    logic [7:0]  words [5];
    logic [1:0]  wrap_exp [5];
    logic [10:0] mid_bits;
    logic [7:0]  b2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        words    = '{8'hB2, 8'h5A, 8'hC3, 8'h01, 8'hFF};
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        mid_bits = {8'hB2, 3'b110};
        b2       = 8'hB2;
        data_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        check("rst_cnt_w2", 32'(w2_frame_cnt), 32'd0);

        // Basic frame, ready tied high
        data_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sync = (i == 0);
            a    = b2[7-i];
            tick();
            if (i == 6) check("basic_valid_early", 32'(data_valid), 32'd0);
        end
        sync = 1'b0;
        a    = 1'b0;
        check("basic_valid", 32'(data_valid), 32'd1);
        check("basic_data", 32'(data_out), 32'hB2);
        check("basic_cnt_pre", 32'(frame_cnt), 32'd0);
        tick();
        check("basic_valid_drop", 32'(data_valid), 32'd0);
        check("basic_cnt", 32'(frame_cnt), 32'd1);
        tick();
        check("basic_valid_once", 32'(data_valid), 32'd0);

        // Back-pressure overrun with back-to-back frames
        do_reset();
        data_ready = 1'b0;
        send_frame(8'hB2, 1'b0);
        check("bp_first_valid", 32'(data_valid), 32'd1);
        send_frame(8'h5A, 1'b0);
        check("bp_overrun", 32'(overrun), 32'd1);
        check("bp_data_hold", 32'(data_out), 32'hB2);
        check("bp_valid_hold", 32'(data_valid), 32'd1);
        check("bp_cnt_zero", 32'(frame_cnt), 32'd0);
        tick();
        check("bp_overrun_once", 32'(overrun), 32'd0);
        tick();
        tick();
        tick();
        check("bp_data_stable", 32'(data_out), 32'hB2);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("bp_accept_valid", 32'(data_valid), 32'd0);
        check("bp_accept_cnt", 32'(frame_cnt), 32'd1);

        // Accept coinciding with a new load
        do_reset();
        data_ready = 1'b0;
        send_frame(8'hB2, 1'b0);
        send_frame(8'h5A, 1'b1);
        check("sim_data", 32'(data_out), 32'h5A);
        check("sim_valid", 32'(data_valid), 32'd1);
        check("sim_overrun", 32'(overrun), 32'd0);
        check("sim_cnt", 32'(frame_cnt), 32'd1);
        tick();
        check("sim_valid_hold", 32'(data_valid), 32'd1);
        check("sim_cnt_hold", 32'(frame_cnt), 32'd1);

        // Sync again three bits into a frame
        do_reset();
        data_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            sync = (i == 0 || i == 3);
            a    = mid_bits[10-i];
            tick();
            if (i == 7) begin
`ifdef SYNC_FRAME_RESYNC_EN
                check("mid_valid_18", 32'(data_valid), 32'd0);
`else
                check("mid_valid_18", 32'(data_valid), 32'd1);
                check("mid_data_18", 32'(data_out), 32'hB2);
`endif
            end
        end
        sync = 1'b0;
        a    = 1'b0;
        check("mid_valid_21", 32'(data_valid), 32'd1);
`ifdef SYNC_FRAME_RESYNC_EN
        check("mid_data_21", 32'(data_out), 32'h96);
`else
        check("mid_data_21", 32'(data_out), 32'hB2);
`endif
        check("mid_overrun", 32'(overrun), 32'd0);

        // Reset mid-frame with a buffered word
        do_reset();
        data_ready = 1'b0;
        send_frame(8'hB2, 1'b0);
        check("rmid_buffered", 32'(data_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            sync = (i == 0);
            a    = b2[7-i];
            tick();
        end
        sync = 1'b0;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
        check("rmid_valid", 32'(data_valid), 32'd0);
        check("rmid_data", 32'(data_out), 32'd0);
        check("rmid_overrun", 32'(overrun), 32'd0);
        check("rmid_cnt", 32'(frame_cnt), 32'd0);
        data_ready = 1'b1;
        send_frame(8'h5A, 1'b0);
        check("rmid_next_valid", 32'(data_valid), 32'd1);
        check("rmid_next_data", 32'(data_out), 32'h5A);
        tick();
        check("rmid_next_cnt", 32'(frame_cnt), 32'd1);

        // Counter wrap on the 2-bit instance
        do_reset();
        data_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send_frame(words[k], 1'b0);
            check("wrap_valid", 32'(data_valid), 32'd1);
            check("wrap_data", 32'(data_out), 32'(words[k]));
            tick();
            check("wrap_cnt_w2", 32'(w2_frame_cnt), 32'(wrap_exp[k]));
            check("wrap_cnt", 32'(frame_cnt), 32'(k + 1));
        end
        data_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sync_frame_deserializer
